fetch_queue: RTL

Parametrised instruction-fetch unit for the next-generation pipelined CPU. Replaces the single-register fetch stage with a prefetch queue. It issues sequential instruction-memory requests over a ready/ack handshake and buffers up to DEPTH instructions with their PCs. It presents them to decode over a valid/ready handshake and flushes on branch/jump redirect. Sits between instruction memory and the decode stage.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/fetch_queue.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch path.
package cpu_pkg;

    // Byte distance between consecutive sequential fetch addresses.
    localparam int unsigned INSN_BYTES = 4;

    // Number of low PC bits forced to zero, which keeps fetches word aligned.
    localparam int unsigned PC_ALIGN_BITS = 2;

    // Fetch address used after reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Width in bits of one queued {pc, insn} entry for a given word width.
    function automatic int unsigned entry_bits(input int unsigned width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries with push, pop and single-cycle flush.
module fetch_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush;

    // Next pointer and occupancy values; a flush empties the queue outright.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block leaves it unassigned, which would infer a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PTR_W'(1);
            if (do_pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only read once count says they were written.
        if (do_push) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch unit: sequential imem requests into a queue
// that feeds decode, with redirect flushing the queue and retargeting fetch.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             ir_valid,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] pc,
    input  logic             ir_ready
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] insn;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = entry_bits(WIDTH);

    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic             unused_addr_bits;

    // Low redirect address bits are architecturally ignored.
    assign unused_addr_bits = ^redirect_addr[PC_ALIGN_BITS-1:0];

    // Request only when there is room; redirect and reset suppress it combinationally.
    assign imem_req  = !rst && !redirect && !fifo_full;
    assign imem_addr = next_pc_q;
    assign accept    = imem_req && imem_ack;

    assign ir_valid  = !fifo_empty && !redirect;
    assign pop       = ir_valid && ir_ready;

    assign push_entry = '{pc: next_pc_q, insn: imem_rdata};

    // Fetch pointer: redirect retargets, otherwise advance one word per accept.
    always_comb begin
        next_pc_d = next_pc_q;
        if (redirect) begin
            next_pc_d = {redirect_addr[WIDTH-1:PC_ALIGN_BITS], PC_ALIGN_BITS'(0)};
        end else if (accept) begin
            next_pc_d = next_pc_q + WIDTH'(INSN_BYTES);
        end
    end

    // Fetch pointer register; reset wins over redirect.
    always_ff @(posedge clk) begin
        if (rst) next_pc_q <= RESET_PC;
        else     next_pc_q <= next_pc_d;
    end

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ir = head_entry.insn;
    assign pc = head_entry.pc;

endmodule
